// File: rtl/fc_layer_driver_if.sv
// Bundle of every signal between the FC layer sequencer and its environment:
// the feature-vector request, the weight ROM port, the single-neuron FC engine
// port and the per-run result outputs. "master" is the sequencer side,
// "slave" is whatever surrounds it (ROM, engine, downstream logic).
interface fc_layer_driver_if #(
    parameter int N_OUT = 5,
    parameter int N_IN  = 30
);
    logic               i_start;
    logic signed [23:0] i_data       [0:N_IN-1];
    logic        [3:0]  o_row_addr;
    logic signed [15:0] i_row_weight [0:N_IN-1];
    logic signed [15:0] i_row_bias;
    logic               o_fc_start;
    logic signed [15:0] o_fc_weight  [0:N_IN-1];
    logic signed [23:0] o_fc_data    [0:N_IN-1];
    logic signed [15:0] o_fc_bias;
    logic signed [31:0] i_fc_output;
    logic               i_fc_finished;
    logic signed [31:0] o_scores     [0:N_OUT-1];
    logic        [3:0]  o_class;
    logic signed [31:0] o_max_score;
    logic               o_valid;
    logic               o_busy;
    logic               o_error;

    modport master (
        input  i_start, i_data, i_row_weight, i_row_bias, i_fc_output, i_fc_finished,
        output o_row_addr, o_fc_start, o_fc_weight, o_fc_data, o_fc_bias,
               o_scores, o_class, o_max_score, o_valid, o_busy, o_error
    );

    modport slave (
        output i_start, i_data, i_row_weight, i_row_bias, i_fc_output, i_fc_finished,
        input  o_row_addr, o_fc_start, o_fc_weight, o_fc_data, o_fc_bias,
               o_scores, o_class, o_max_score, o_valid, o_busy, o_error
    );
endinterface

// File: rtl/fc_layer_driver.sv
// Sequencer that runs a single-neuron FC engine once per output neuron of a
// classifier layer: latches the feature vector, walks the weight ROM row by
// row, collects each score and tracks the argmax (ties keep the lowest index).
module fc_layer_driver #(
    parameter int N_OUT   = 5,
    parameter int N_IN    = 30,
    parameter int TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_rst_n,   // synchronous, active-high despite the name
    fc_layer_driver_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_FETCH,
        S_KICK,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic        [3:0]  row_reg;
    logic        [3:0]  row_addr_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic signed [23:0] data_reg   [0:N_IN-1];
    logic signed [15:0] weight_reg [0:N_IN-1];
    logic signed [15:0] bias_reg;
    logic signed [31:0] scores_reg [0:N_OUT-1];
    logic        [3:0]  class_reg;
    logic signed [31:0] max_score_reg;
    logic               fc_start_reg;
    logic               valid_reg;
    logic               error_reg;
    logic               last_row;
    logic               new_max;

    // Row 0 always seeds the tracker; later rows must be strictly greater so
    // that equal scores keep the lower index.
    assign last_row = (row_reg == 4'(N_OUT - 1));
    assign new_max  = (row_reg == 4'd0) || (bus.i_fc_output > max_score_reg);
    assign cnt_next = cnt_reg + CNT_W'(1);

    // Single FSM: sequencing, operand registers, score capture and argmax.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            state_reg     <= S_IDLE;
            row_reg       <= '0;
            row_addr_reg  <= '0;
            cnt_reg       <= '0;
            bias_reg      <= '0;
            class_reg     <= '0;
            max_score_reg <= '0;
            fc_start_reg  <= 1'b0;
            valid_reg     <= 1'b0;
            error_reg     <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                data_reg[i]   <= '0;
                weight_reg[i] <= '0;
            end
            for (int i = 0; i < N_OUT; i++) begin
                scores_reg[i] <= '0;
            end
        end else begin
            fc_start_reg <= 1'b0;
            valid_reg    <= 1'b0;
            error_reg    <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.i_start) begin
                        for (int i = 0; i < N_IN; i++) begin
                            data_reg[i] <= bus.i_data[i];
                        end
                        row_reg       <= '0;
                        row_addr_reg  <= '0;
                        max_score_reg <= '0;
                        class_reg     <= '0;
                        state_reg     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    // ROM registers row_addr_reg at the end of this cycle.
                    state_reg <= S_FETCH;
                end
                S_FETCH: begin
                    for (int i = 0; i < N_IN; i++) begin
                        weight_reg[i] <= bus.i_row_weight[i];
                    end
                    bias_reg     <= bus.i_row_bias;
                    fc_start_reg <= 1'b1;   // high during S_KICK only
                    state_reg    <= S_KICK;
                end
                S_KICK: begin
                    cnt_reg   <= '0;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.i_fc_finished) begin
                        for (int i = 0; i < N_OUT; i++) begin
                            if (row_reg == 4'(i)) begin
                                scores_reg[i] <= bus.i_fc_output;
                            end
                        end
                        if (new_max) begin
                            max_score_reg <= bus.i_fc_output;
                            class_reg     <= row_reg;
                        end
                        if (last_row) begin
                            valid_reg <= 1'b1;   // visible during S_DONE
                            state_reg <= S_DONE;
                        end else begin
                            row_reg      <= row_reg + 4'd1;
                            row_addr_reg <= row_reg + 4'd1;
                            state_reg    <= S_ADDR;
                        end
                    end else if (cnt_next == CNT_W'(TIMEOUT)) begin
                        // TIMEOUT silent wait cycles: abort; error shows in the first idle cycle.
                        error_reg <= 1'b1;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_row_addr  = row_addr_reg;
    assign bus.o_fc_start  = fc_start_reg;
    assign bus.o_fc_bias   = bias_reg;
    assign bus.o_class     = class_reg;
    assign bus.o_max_score = max_score_reg;
    assign bus.o_valid     = valid_reg;
    assign bus.o_error     = error_reg;
    assign bus.o_busy      = (state_reg != S_IDLE);

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_operands
            assign bus.o_fc_data[gi]   = data_reg[gi];
            assign bus.o_fc_weight[gi] = weight_reg[gi];
        end
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_scores
            assign bus.o_scores[gi] = scores_reg[gi];
        end
    endgenerate
endmodule

// File: tb/tb_fc_layer_driver.sv
// Directed + randomized bench for fc_layer_driver with a behavioural weight ROM,
// a behavioural FC engine (Q8 data: (sum d*w) >>> 8 plus bias, done two cycles
// after start) and a reference model that recomputes scores and argmax.
module tb_fc_layer_driver;
    localparam int N_OUT   = 5;
    localparam int N_IN    = 30;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fc_layer_driver_if #(.N_OUT(N_OUT), .N_IN(N_IN)) bus ();

    fc_layer_driver #(.N_OUT(N_OUT), .N_IN(N_IN), .TIMEOUT(TIMEOUT)) dut (
        .i_clk  (clk),
        .i_rst_n(rst),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    logic signed [15:0] rom_w [0:15][0:N_IN-1];
    logic signed [15:0] rom_b [0:15];
    logic signed [23:0] vec   [0:N_IN-1];
    logic signed [23:0] lat   [0:N_IN-1];
    logic signed [31:0] exp_scores [0:N_OUT-1];
    logic        [3:0]  exp_class;
    logic signed [31:0] exp_max;
    logic               fc_en;
    logic               fc_pend;
    longint             fc_sum;
    logic [63:0]        kick_m, valid_m, err_m, busy_m;
    int                 data_bad;

    // Weight ROM with one cycle of read latency.
    always @(posedge clk) begin
        for (int i = 0; i < N_IN; i++) begin
            bus.i_row_weight[i] <= rom_w[bus.o_row_addr][i];
        end
        bus.i_row_bias <= rom_b[bus.o_row_addr];
    end

    // Engine dot product over the presented operands.
    always_comb begin
        fc_sum = 0;
        for (int i = 0; i < N_IN; i++) begin
            fc_sum = fc_sum + longint'(bus.o_fc_data[i]) * longint'(bus.o_fc_weight[i]);
        end
    end

    // Engine timing: start seen at edge E, result + finished pulse after edge E+1.
    always @(posedge clk) begin
        if (rst) begin
            fc_pend           <= 1'b0;
            bus.i_fc_finished <= 1'b0;
            bus.i_fc_output   <= '0;
        end else begin
            fc_pend           <= bus.o_fc_start & fc_en;
            bus.i_fc_finished <= fc_pend;
            if (fc_pend) begin
                bus.i_fc_output <= 32'((fc_sum >>> 8) + longint'(bus.o_fc_bias));
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: each score is the Q8 dot product plus bias; argmax = first maximum.
    task automatic model();
        for (int r = 0; r < N_OUT; r++) begin
            longint acc = 0;
            for (int i = 0; i < N_IN; i++) begin
                acc += longint'(lat[i]) * longint'(rom_w[r][i]);
            end
            exp_scores[r] = 32'((acc >>> 8) + longint'(rom_b[r]));
        end
        exp_class = 4'd0;
        exp_max   = exp_scores[0];
        for (int r = 1; r < N_OUT; r++) begin
            if (exp_scores[r] > exp_max) begin
                exp_max   = exp_scores[r];
                exp_class = 4'(r);
            end
        end
    endtask

    // mode 0: weights r; 1: weights 0 bias 7; 2: weights -(r+1); 3: random.
    task automatic load_rows(input int mode);
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < N_IN; i++) begin
                case (mode)
                    0:       rom_w[r][i] = 16'(r);
                    1:       rom_w[r][i] = 16'sd0;
                    2:       rom_w[r][i] = 16'(-(r + 1));
                    default: rom_w[r][i] = 16'(int'($urandom_range(0, 2046)) - 1023);
                endcase
            end
            case (mode)
                1:       rom_b[r] = 16'sd7;
                3:       rom_b[r] = 16'(int'($urandom_range(0, 4000)) - 2000);
                default: rom_b[r] = 16'sd0;
            endcase
        end
    endtask

    task automatic set_vec(input bit random_data);
        for (int i = 0; i < N_IN; i++) begin
            vec[i] = random_data ? 24'(int'($urandom_range(0, 8190)) - 4095) : 24'sd256;
        end
    endtask

    // Presents i_start for one cycle (T0) with the current vector.
    task automatic begin_run();
        @(negedge clk);
        for (int i = 0; i < N_IN; i++) begin
            lat[i]         = vec[i];
            bus.i_data[i]  = vec[i];
        end
        bus.i_start = 1'b1;
    endtask

    // Samples cycles T1..Tn; optionally re-asserts i_start with fresh data.
    task automatic run_cycles(input int n, input logic [63:0] restart_mask);
        kick_m = '0; valid_m = '0; err_m = '0; busy_m = '0; data_bad = 0;
        for (int t = 1; t <= n; t++) begin
            @(posedge clk);
            @(negedge clk);
            bus.i_start = restart_mask[t];
            if (restart_mask[t]) begin
                for (int i = 0; i < N_IN; i++) bus.i_data[i] = 24'($urandom);
            end
            kick_m[t]  = bus.o_fc_start;
            valid_m[t] = bus.o_valid;
            err_m[t]   = bus.o_error;
            busy_m[t]  = bus.o_busy;
            if (bus.o_busy) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (bus.o_fc_data[i] !== lat[i]) data_bad++;
                end
            end
        end
    endtask

    // Expected: kick at T3+5k, valid at T(5*N_OUT+1), busy T1..T(5*N_OUT+1).
    task automatic check_timing(input string tag, input int n);
        logic [63:0] ek, ev, eb;
        ek = '0; ev = '0; eb = '0;
        for (int k = 0; k < N_OUT; k++) if (3 + 5 * k <= n) ek[3 + 5 * k] = 1'b1;
        if (5 * N_OUT + 1 <= n) ev[5 * N_OUT + 1] = 1'b1;
        for (int t = 1; t <= n && t <= 5 * N_OUT + 1; t++) eb[t] = 1'b1;
        chk({tag, "_kick"}, kick_m, ek);
        chk({tag, "_valid"}, valid_m, ev);
        chk({tag, "_busy"}, busy_m, eb);
        chk({tag, "_error"}, err_m, 64'd0);
        chk({tag, "_data_stable"}, 64'(data_bad), 64'd0);
    endtask

    task automatic check_results(input string tag);
        model();
        for (int r = 0; r < N_OUT; r++) begin
            chk($sformatf("%s_score%0d", tag, r), bus.o_scores[r], exp_scores[r]);
        end
        chk({tag, "_class"}, bus.o_class, exp_class);
        chk({tag, "_max"}, bus.o_max_score, exp_max);
    endtask

    task automatic chk_zero(input string tag);
        int nz = 0;
        if (bus.o_busy !== 1'b0) nz++;
        if (bus.o_valid !== 1'b0) nz++;
        if (bus.o_error !== 1'b0) nz++;
        if (bus.o_fc_start !== 1'b0) nz++;
        if (bus.o_row_addr !== 4'd0) nz++;
        if (bus.o_class !== 4'd0) nz++;
        if (bus.o_max_score !== 32'sd0) nz++;
        if (bus.o_fc_bias !== 16'sd0) nz++;
        for (int r = 0; r < N_OUT; r++) if (bus.o_scores[r] !== 32'sd0) nz++;
        for (int i = 0; i < N_IN; i++) begin
            if (bus.o_fc_data[i] !== 24'sd0) nz++;
            if (bus.o_fc_weight[i] !== 16'sd0) nz++;
        end
        chk({tag, "_busy"}, bus.o_busy, 1'b0);
        chk({tag, "_nonzero"}, 64'(nz), 64'd0);
    endtask

    initial begin
        logic [63:0] restarts;
        fc_en = 1'b1;
        rst = 1'b1;
        bus.i_start = 1'b0;
        load_rows(0);
        set_vec(0);
        for (int i = 0; i < N_IN; i++) bus.i_data[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_zero("reset");

        // Ascending weights: scores 0,30,60,90,120
        load_rows(0); set_vec(0);
        begin_run(); run_cycles(28, 64'd0);
        check_timing("ramp", 28);
        check_results("ramp");
        chk("ramp_class_lit", bus.o_class, 4'd4);
        chk("ramp_max_lit", bus.o_max_score, 64'd120);
        $display("[TB] ramp run: class=%0d max=%0d", bus.o_class, bus.o_max_score);

        // All-equal scores: tie keeps index 0
        load_rows(1);
        begin_run(); run_cycles(28, 64'd0);
        check_timing("tie", 28);
        check_results("tie");
        chk("tie_class_lit", bus.o_class, 4'd0);
        $display("[TB] tie run: class=%0d max=%0d", bus.o_class, bus.o_max_score);

        // Negative scores: signed compare picks row 0 (-30)
        load_rows(2);
        begin_run(); run_cycles(28, 64'd0);
        check_timing("neg", 28);
        check_results("neg");
        chk("neg_max_lit", bus.o_max_score, -64'sd30);
        $display("[TB] negative run: class=%0d max=%0d", bus.o_class, bus.o_max_score);

        // i_start re-asserted at T5 and T12 with new data: ignored
        load_rows(0); set_vec(0);
        restarts = '0; restarts[5] = 1'b1; restarts[12] = 1'b1;
        begin_run(); run_cycles(28, restarts);
        check_timing("restart", 28);
        check_results("restart");
        $display("[TB] restart-ignored run: class=%0d max=%0d", bus.o_class, bus.o_max_score);

        // Random runs, each started the cycle after the previous o_valid
        load_rows(3);
        for (int k = 0; k < 4; k++) begin
            set_vec(1);
            begin_run(); run_cycles(26, 64'd0);
            check_timing($sformatf("rand%0d", k), 26);
            check_results($sformatf("rand%0d", k));
            $display("[TB] random run %0d: class=%0d max=%0d", k, bus.o_class, bus.o_max_score);
        end

        // Engine never finishes: error one cycle after 15 wait cycles, no valid
        fc_en = 1'b0;
        begin_run(); run_cycles(30, 64'd0);
        begin
            logic [63:0] eb;
            eb = '0;
            for (int t = 1; t <= 3 + TIMEOUT; t++) eb[t] = 1'b1;
            chk("tmo_error", err_m, 64'd1 << (4 + TIMEOUT));
            chk("tmo_valid", valid_m, 64'd0);
            chk("tmo_busy", busy_m, eb);
            chk("tmo_kick", kick_m, 64'd1 << 3);
        end
        for (int r = 0; r < N_OUT; r++) begin
            chk($sformatf("tmo_keep_score%0d", r), bus.o_scores[r], exp_scores[r]);
        end
        chk("tmo_class", bus.o_class, 4'd0);
        chk("tmo_max", bus.o_max_score, 64'd0);
        $display("[TB] timeout run: error pulses=%0d", $countones(err_m));
        fc_en = 1'b1;

        // Reset at T10 mid-run, then a fresh run completes normally
        load_rows(0); set_vec(1);
        begin_run(); run_cycles(10, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", valid_m, 64'd0);
        chk("midrst_error", err_m, 64'd0);
        chk_zero("midrst");
        $display("[TB] mid-run reset: outputs cleared");
        begin_run(); run_cycles(28, 64'd0);
        check_timing("after_rst", 28);
        check_results("after_rst");
        $display("[TB] post-reset run: class=%0d max=%0d", bus.o_class, bus.o_max_score);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fc_layer_driver.md
# fc_layer_driver

Sequencer that drives the single-neuron fully connected engine (`FC`) through all output neurons of one classifier layer. It latches a 30-element feature vector, fetches each neuron's weight row and bias from a registered weight ROM, and pulses the engine's start input once per neuron. It collects each 32-bit score and reports all scores plus the argmax class. It sits between the feature-extraction stage and the gesture-decision logic.

## Interface
- `N_OUT`, default 5: number of output neurons (rows). Legal range 1..16.
- `N_IN`, default 30: inputs per neuron. Must equal the `FC` vector length.
- `TIMEOUT`, default 15: maximum number of S_WAIT cycles before abort.
- `i_clk`  in  1  clock; the block's only clock.
- `i_rst_n`  in  1  reset; synchronous, active-high despite the name.
- `i_start`  in  1  run request; sampled only in S_IDLE.
- `i_data[0:N_IN-1]`  in  24 signed each  feature vector; latched when `i_start` is accepted.
- `o_row_addr`  out  4  weight ROM row address (registered).
- `i_row_weight[0:N_IN-1]`  in  16 signed each  ROM weight row; valid in the cycle after the cycle in which `o_row_addr` is presented.
- `i_row_bias`  in  16 signed  ROM bias; same timing as `i_row_weight`.
- `o_fc_start`  out  1  one-cycle start pulse to `FC`.
- `o_fc_weight[0:N_IN-1]`  out  16 signed  registered weight row to `FC`.
- `o_fc_data[0:N_IN-1]`  out  24 signed  registered feature vector to `FC`.
- `o_fc_bias`  out  16 signed  registered bias to `FC`.
- `i_fc_output`  in  32 signed  `FC` result.
- `i_fc_finished`  in  1  `FC` one-cycle done pulse.
- `o_scores[0:N_OUT-1]`  out  32 signed  per-neuron scores.
- `o_class`  out  4  argmax index.
- `o_max_score`  out  32 signed  score at `o_class`.
- `o_valid`  out  1  one-cycle pulse when a run completes.
- `o_busy`  out  1  high in every state except S_IDLE.
- `o_error`  out  1  one-cycle pulse on `FC` timeout.

## Operation
- States: S_IDLE, S_ADDR, S_FETCH, S_KICK, S_WAIT, S_DONE.
- S_IDLE, on `i_start`:
  - latch `i_data` into the data registers;
  - set row=0 and `o_row_addr`=0;
  - clear the max tracker;
  - go to S_ADDR.
- S_ADDR: hold `o_row_addr`=row, which the ROM registers. Go to S_FETCH.
- S_FETCH: register `i_row_weight` and `i_row_bias` into the `o_fc_*` registers. Go to S_KICK.
- S_KICK: `o_fc_start`=1 for this cycle only. Clear the timeout counter. Go to S_WAIT.
- S_WAIT, on `i_fc_finished`:
  - `o_scores[row]` <= `i_fc_output`;
  - if row==0 or `i_fc_output` > `o_max_score` (signed, strict), then `o_max_score` <= `i_fc_output` and `o_class` <= row;
  - if row==N_OUT-1, go to S_DONE; otherwise row++, `o_row_addr` <= row+1, and go to S_ADDR.
- S_WAIT without `i_fc_finished`: increment the counter. When the counter reaches TIMEOUT, pulse `o_error` and go to S_IDLE. Outputs from the aborted run are left partially updated, and `o_valid` is not pulsed.
- S_DONE: `o_valid`=1 for one cycle, then go to S_IDLE.
- Ties keep the lowest index.
- `o_fc_data`, `o_fc_weight` and `o_fc_bias` stay stable from S_KICK through the `i_fc_finished` cycle.
- `i_start` outside S_IDLE is ignored. No queuing.
- `i_fc_finished` outside S_WAIT is ignored.
- Result outputs hold their values until overwritten by the next run.

## Timing
- Reset (synchronous, `i_rst_n`=1 at a rising edge): all outputs, score array, data/weight/bias registers and counters go to 0; state goes to S_IDLE. Reset mid-run aborts immediately with no `o_valid` and no `o_error`.
- Per row: S_ADDR, S_FETCH, S_KICK, then S_WAIT.
  - With `FC` as specified, start sampled at the end of S_KICK gives `i_fc_finished` in the second S_WAIT cycle.
  - So each row takes 5 cycles.
- `i_start` sampled at the end of cycle T0:
  - row k S_ADDR is at T1+5k;
  - `o_valid` is at T0+5·N_OUT+1 (T26 for N_OUT=5).
- A new `i_start` is accepted the cycle after `o_valid`, with `o_busy` low in that cycle.
- `i_fc_finished` with row==N_OUT-1 and a new maximum: the score and argmax updates land on the same edge, and both are visible in the S_DONE cycle.

## Test plan
- Real `FC` instance; `i_data` all 256; row r weights all r; biases 0; `i_start` at T0 -> scores 0,30,60,90,120; `o_class`=4; `o_max_score`=120; `o_valid` only at T26; `o_fc_start` high exactly at T3,T8,T13,T18,T23.
- All weights 0, all biases 7 -> scores all 7; `o_class`=0 (tie rule).
- `i_data` all 256; row r weights all −(r+1) -> scores −30,−60,−90,−120,−150; `o_class`=0; `o_max_score`=−30 (signed compare).
- `i_start` re-asserted at T5 and T12 during a run -> ignored; a single `o_valid` at T26; `o_fc_data` unchanged even though `i_data` changes.
- `FC` stub that never finishes -> `o_error` pulses once 15 cycles into S_WAIT; `o_busy` drops the next cycle; `o_valid` never asserts.
- `i_rst_n` asserted at T10 -> next cycle all outputs are 0 and the state is S_IDLE; a fresh `i_start` then completes normally 26 cycles later.
